// File: rtl/data_axi_bridge.sv
// data_axi_bridge: converts a CPU SRAM-style data request into a single-beat AXI read or write,
// stalling the CPU until the transfer completes.
`default_nettype none

module data_axi_bridge #(
   parameter int MASK_KSEG = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_en,
   input  logic [3:0]  req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] req_rdata,
   output logic        req_stall,
   output logic        bus_err,
   output logic [31:0] axi_araddr,
   output logic [2:0]  axi_arsize,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   input  logic [31:0] axi_rdata,
   input  logic [1:0]  axi_rresp,
   input  logic        axi_rvalid,
   output logic        axi_rready,
   output logic [31:0] axi_awaddr,
   output logic [2:0]  axi_awsize,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [31:0] axi_wdata,
   output logic [3:0]  axi_wstrb,
   output logic        axi_wvalid,
   input  logic        axi_wready,
   input  logic [1:0]  axi_bresp,
   input  logic        axi_bvalid,
   output logic        axi_bready
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ADDR = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR_ADDR = 3'd3,
      S_WR_RESP = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_stall;
   logic [31:0] w_phys_addr;
   logic [2:0]  w_awsize;
   logic        w_aw_ok;
   logic        w_w_ok;

   logic [31:0] r_addr;
   logic [3:0]  r_wen;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [2:0]  r_arsize;
   logic [2:0]  r_awsize;
   logic        r_arvalid;
   logic        r_rready;
   logic        r_awvalid;
   logic        r_wvalid;
   logic        r_bready;
   logic        r_bus_err;

   assign w_phys_addr = (MASK_KSEG != 0) ? {3'b000, req_addr[28:0]} : req_addr;

   // Each write channel is satisfied once its valid has dropped or it handshakes now.
   assign w_aw_ok = !r_awvalid || axi_awready;
   assign w_w_ok  = !r_wvalid  || axi_wready;

   always_comb begin
      w_awsize = 3'd2;
      case (req_wen)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: w_awsize = 3'd0;
         4'b0011, 4'b0101, 4'b0110,
         4'b1001, 4'b1010, 4'b1100:          w_awsize = 3'd1;
         default:                            w_awsize = 3'd2;
      endcase
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_en) begin
               w_stall = 1'b1;
               w_next  = (req_wen == 4'b0000) ? S_RD_ADDR : S_WR_ADDR;
            end
         end
         S_RD_ADDR: begin
            w_stall = 1'b1;
            if (r_arvalid && axi_arready) w_next = S_RD_DATA;
         end
         S_RD_DATA: begin
            w_stall = 1'b1;
            if (r_rready && axi_rvalid) w_next = S_DONE;
         end
         S_WR_ADDR: begin
            w_stall = 1'b1;
            if (w_aw_ok && w_w_ok) w_next = S_WR_RESP;
         end
         S_WR_RESP: begin
            w_stall = 1'b1;
            if (r_bready && axi_bvalid) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_addr    <= '0;
         r_wen     <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_arsize  <= '0;
         r_awsize  <= '0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_en) begin
                  r_addr  <= w_phys_addr;
                  r_wen   <= req_wen;
                  r_wdata <= req_wdata;
                  if (req_wen == 4'b0000) begin
                     r_arvalid <= 1'b1;
                     r_arsize  <= 3'b010;
                  end else begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_awsize  <= w_awsize;
                  end
               end
            end
            S_RD_ADDR: begin
               if (axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
               end
            end
            S_RD_DATA: begin
               if (axi_rvalid) begin
                  r_rready  <= 1'b0;
                  r_rdata   <= axi_rdata;
                  r_bus_err <= (axi_rresp != 2'b00);
               end
            end
            S_WR_ADDR: begin
               if (r_awvalid && axi_awready) r_awvalid <= 1'b0;
               if (r_wvalid && axi_wready)   r_wvalid  <= 1'b0;
               if (w_aw_ok && w_w_ok)        r_bready  <= 1'b1;
            end
            S_WR_RESP: begin
               if (axi_bvalid) begin
                  r_bready  <= 1'b0;
                  r_bus_err <= (axi_bresp != 2'b00);
               end
            end
            default: ;
         endcase
      end
   end

   assign req_rdata   = r_rdata;
   assign req_stall   = w_stall;
   assign bus_err     = r_bus_err;
   assign axi_araddr  = r_addr;
   assign axi_arsize  = r_arsize;
   assign axi_arvalid = r_arvalid;
   assign axi_rready  = r_rready;
   assign axi_awaddr  = r_addr;
   assign axi_awsize  = r_awsize;
   assign axi_awvalid = r_awvalid;
   assign axi_wdata   = r_wdata;
   assign axi_wstrb   = r_wen;
   assign axi_wvalid  = r_wvalid;
   assign axi_bready  = r_bready;

endmodule

`default_nettype wire

// File: doc/data_axi_bridge.md
DATA_AXI_BRIDGE -- requirements
Module: data_axi_bridge

Interface
REQ-001 Parameter MASK_KSEG, default 1: when 1, AXI addresses are {3'b000, req_addr[28:0]} (kseg0/kseg1 to physical); when 0, req_addr passes unchanged.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 req_en  input  1  CPU data-SRAM-style request valid.
REQ-005 req_wen  input  4  byte write enables; 0 = read, nonzero = write.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  write data, already byte-lane aligned.
REQ-008 req_rdata  output  32  read data returned to CPU.
REQ-009 req_stall  output  1  CPU must hold its memory stage while high.
REQ-010 bus_err  output  1  one-cycle pulse: the completing transaction returned a non-OKAY response.
REQ-011 axi_araddr  output  32; axi_arsize  output  3; axi_arvalid  output  1; axi_arready  input  1.
REQ-012 axi_rdata  input  32; axi_rresp  input  2; axi_rvalid  input  1; axi_rready  output  1.
REQ-013 axi_awaddr  output  32; axi_awsize  output  3; axi_awvalid  output  1; axi_awready  input  1.
REQ-014 axi_wdata  output  32; axi_wstrb  output  4; axi_wvalid  output  1; axi_wready  input  1.
REQ-015 axi_bresp  input  2; axi_bvalid  input  1; axi_bready  output  1.
REQ-016 Single-beat transfers only; ID/LEN/BURST/LOCK/CACHE/PROT fields are tied off outside this block.

Function
REQ-017 FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE.
REQ-018 IDLE, req_en=1: latch addr/wen/wdata; go RD_ADDR if req_wen==0, else WR_ADDR; req_en=0: stay IDLE.
REQ-019 RD_ADDR: axi_arvalid=1, axi_arsize=3'b010; on arvalid&arready go RD_DATA.
REQ-020 RD_DATA: axi_rready=1; on rvalid latch axi_rdata into req_rdata, latch rresp!=0 as error flag, go DONE.
REQ-021 WR_ADDR: awvalid and wvalid asserted together on entry; each deasserts the cycle after its own handshake; go WR_RESP once both handshakes have occurred, in either order or in the same cycle.
REQ-022 axi_wstrb = latched req_wen; axi_awsize = 0 for one enabled byte, 1 for two, 2 for four; other wen patterns use 2.
REQ-023 WR_RESP: axi_bready=1; on bvalid latch bresp!=0 as error flag, go DONE.
REQ-024 DONE: lasts exactly one cycle, then IDLE; bus_err = error flag in this cycle only.
REQ-025 req_stall = (state==IDLE & req_en) | (state not in {IDLE, DONE}); combinational; low in DONE.
REQ-026 req_rdata holds its last read value until the next read completes; it is unchanged by writes.
REQ-027 All AXI valid/ready outputs are registered and glitch-free; address/data outputs are stable while their valid is high.
REQ-028 Zero-latency case: arready=1 and rvalid in the next cycle gives stall high for 3 cycles, then DONE.
REQ-029 A request in DONE is not re-accepted; a req_en seen in the following IDLE cycle is a new request.
REQ-030 At most one outstanding transaction; no read/write overlap.

Reset
REQ-031 resetn=0 immediately forces: state IDLE, all axi_*valid=0, axi_rready=0, axi_bready=0, bus_err=0, req_rdata=0, address/data/strobe/size outputs=0.
REQ-032 Reset mid-transaction abandons the transfer without completion; the interconnect is reset by the same system reset.

Verification
REQ-033 Read 0x9FC0_0010, arready=1, rvalid next cycle with 0x1234_5678 -> araddr=0x1FC0_0010, stall high 3 cycles, DONE req_rdata=0x1234_5678.
REQ-034 Write wen=4'b0011 addr 0xA000_0002 data 0x0000_BEEF -> awaddr=0x0000_0002, awsize=1, wstrb=0011; bvalid after 2 cycles -> DONE, bus_err=0.
REQ-035 Write with wready 3 cycles later than awready, then both in same cycle on a second write -> each valid drops only after its own handshake, both writes complete.
REQ-036 Read with rresp=2'b10 -> bus_err=1 for exactly the DONE cycle, data still returned.
REQ-037 resetn low during RD_DATA -> all valids/readies 0 asynchronously; after release, state IDLE and stall=0 while req_en=0.
REQ-038 Back-to-back req_en held high across DONE -> two distinct transactions issued, with one non-stall cycle between them.
